// File: rtl/syn_current_acc_pkg.sv
// syn_current_acc_pkg: shared FSM encoding and default widths for the synaptic current accumulator
package syn_current_acc_pkg;
    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;
    localparam int DEF_WIDTH  = 23;
    localparam int DEF_WEIGHT = 7;
endpackage

// File: rtl/syn_current_acc_sat_add.sv
// syn_sat_add: acc + sext(weight); saturates to the WIDTH rails under SYN_ACC_SATURATE_EN, wraps otherwise
import syn_current_acc_pkg::*;
module syn_sat_add #(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WEIGHT = DEF_WEIGHT
) (
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WEIGHT-1:0] b,
    output logic signed [WIDTH-1:0]  y
);
`ifdef SYN_ACC_SATURATE_EN
    logic signed [WIDTH:0] s;
    // one guard bit exposes overflow; clamp to the rail matching the true sign
    always_comb begin
        s = (WIDTH+1)'(a) + (WIDTH+1)'(b);
        y = (s[WIDTH] != s[WIDTH-1]) ? (s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : s[WIDTH-1:0];
    end
`else
    // plain two's-complement add, overflow wraps
    always_comb y = a + WIDTH'(b);
`endif
endmodule

// File: rtl/syn_current_acc.sv
// syn_current_acc: accumulates FAN_IN spike-gated weights per neuron, emits one current pulse per neuron (SYN_ACC_SATURATE_EN selects saturation)
import syn_current_acc_pkg::*;
module syn_current_acc #(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int WEIGHT  = DEF_WEIGHT,
    parameter int FAN_IN  = 64,
    parameter int NEURONS = 717
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     spike_in,
    input  logic signed [WEIGHT-1:0] weight_in,
    output logic                     cur_valid,
    output logic signed [WIDTH-1:0]  synaptic_current,
    output logic                     busy,
    output logic                     done
);
    localparam int FW = FAN_IN  > 1 ? $clog2(FAN_IN)  : 1;
    localparam int NW = NEURONS > 1 ? $clog2(NEURONS) : 1;

    state_t                    state;
    logic signed [WIDTH-1:0]   acc, sum;
    logic signed [WEIGHT-1:0]  w;
    logic [FW-1:0]             fan_cnt;
    logic [NW-1:0]             nrn_cnt;

    assign in_ready = state == ACC;
    assign busy     = state != IDLE;

    // a silent beat contributes nothing
    always_comb w = spike_in ? weight_in : '0;

    syn_sat_add #(.WIDTH(WIDTH), .WEIGHT(WEIGHT)) u_add (.a(acc), .b(w), .y(sum));

    // frame sequencing, beat accumulation and registered result/pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            acc              <= '0;
            fan_cnt          <= '0;
            nrn_cnt          <= '0;
            cur_valid        <= 1'b0;
            done             <= 1'b0;
            synaptic_current <= '0;
        end else begin
            cur_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) state <= ACC;
                ACC: if (in_valid) begin
                    acc <= sum;
                    if (fan_cnt == FW'(FAN_IN-1)) begin
                        fan_cnt          <= '0;
                        state            <= EMIT;
                        synaptic_current <= sum;
                        cur_valid        <= 1'b1;
                        done             <= nrn_cnt == NW'(NEURONS-1);
                    end else begin
                        fan_cnt <= fan_cnt + FW'(1);
                    end
                end
                EMIT: begin
                    acc <= '0;
                    if (nrn_cnt == NW'(NEURONS-1)) begin
                        nrn_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        nrn_cnt <= nrn_cnt + NW'(1);
                        state   <= ACC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
